// File: rtl/dma_transfer_ctrl_if.sv
// Host-side control and status bundle for the DMA transfer controller.
// The controller connects through the slave modport; the host/register side uses master.
interface dma_transfer_ctrl_if #(
  parameter int BLK_CNT_W  = 16,
  parameter int BLK_SIZE_W = 12
);
  logic [15:0]           transfer_mode_register;
  logic [BLK_CNT_W-1:0]  block_count_register;
  logic [BLK_SIZE_W-1:0] block_size;
  logic [7:0]            block_gap_control_register;
  logic                  start;
  logic                  abort;
  logic                  word_done;

  logic                  read_transfer_active;
  logic                  write_transfer_active;
  logic                  dma_request;
  logic                  block_done;
  logic                  block_gap_event;
  logic                  transfer_complete;
  logic [BLK_CNT_W-1:0]  blocks_remaining;

  modport master (
    output transfer_mode_register, block_count_register, block_size,
           block_gap_control_register, start, abort, word_done,
    input  read_transfer_active, write_transfer_active, dma_request,
           block_done, block_gap_event, transfer_complete, blocks_remaining
  );

  modport slave (
    input  transfer_mode_register, block_count_register, block_size,
           block_gap_control_register, start, abort, word_done,
    output read_transfer_active, write_transfer_active, dma_request,
           block_done, block_gap_event, transfer_complete, blocks_remaining
  );
endinterface

// File: rtl/dma_transfer_ctrl.sv
// Block-oriented DMA transfer sequencer: counts bytes per block, tracks remaining
// blocks, and handles block-gap stop/continue, abort and completion.
module dma_transfer_ctrl #(
  parameter int BLK_CNT_W  = 16,
  parameter int BLK_SIZE_W = 12,
  parameter int DATA_BYTES = 4
) (
  input logic                clk,
  input logic                rst,
  dma_transfer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STOPPED  = 2'd2,
    COMPLETE = 2'd3
  } state_e;

  typedef struct packed {
    logic multi;
    logic dir;
    logic cnt_en;
    logic dma_en;
  } ctrl_t;

  localparam int                BYTE_W    = BLK_SIZE_W + 1;
  localparam logic [BYTE_W-1:0] WORD_STEP = BYTE_W'(DATA_BYTES);

  state_e                state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d, ctrl_new;
  logic [BLK_SIZE_W-1:0] blk_size_q, blk_size_d;
  logic [BYTE_W-1:0]     byte_cnt_q, byte_cnt_d, byte_next;
  logic [BLK_CNT_W-1:0]  blocks_rem_q, blocks_rem_d, rem_after;
  logic                  block_done_q, block_done_d;
  logic                  gap_event_q, gap_event_d;
  logic                  xfer_done_q, xfer_done_d;
  logic                  counted;
  logic                  end_of_block;
  logic                  in_xfer;
  logic                  unused_bits;

  assign ctrl_new = '{multi:  bus.transfer_mode_register[5],
                      dir:    bus.transfer_mode_register[4],
                      cnt_en: bus.transfer_mode_register[1],
                      dma_en: bus.transfer_mode_register[0]};

  // Infinite mode (multi-block without count enable) never decrements.
  assign counted      = !ctrl_q.multi || ctrl_q.cnt_en;
  assign byte_next    = byte_cnt_q + WORD_STEP;
  assign end_of_block = byte_next >= {1'b0, blk_size_q};
  assign rem_after    = (counted && blocks_rem_q != '0) ? blocks_rem_q - BLK_CNT_W'(1)
                                                        : blocks_rem_q;

  // NOTE: every variable is given its default before the case, so no path
  // through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    ctrl_d       = ctrl_q;
    blk_size_d   = blk_size_q;
    byte_cnt_d   = byte_cnt_q;
    blocks_rem_d = blocks_rem_q;
    block_done_d = 1'b0;
    gap_event_d  = 1'b0;
    xfer_done_d  = 1'b0;

    if (bus.abort) begin
      state_d      = IDLE;
      ctrl_d       = '0;
      byte_cnt_d   = '0;
      blocks_rem_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && bus.block_size != '0) begin
            ctrl_d       = ctrl_new;
            blk_size_d   = bus.block_size;
            byte_cnt_d   = '0;
            blocks_rem_d = ctrl_new.multi ? bus.block_count_register : BLK_CNT_W'(1);
            if (ctrl_new.multi && ctrl_new.cnt_en && bus.block_count_register == '0)
              state_d = COMPLETE;
            else
              state_d = ACTIVE;
          end
        end

        ACTIVE: begin
          if (bus.word_done) begin
            if (end_of_block) begin
              byte_cnt_d   = '0;
              block_done_d = 1'b1;
              blocks_rem_d = rem_after;
              // Reaching the final block takes precedence over a gap-stop request.
              if (counted && rem_after == '0) begin
                state_d = COMPLETE;
              end else if (bus.block_gap_control_register[0]) begin
                state_d     = STOPPED;
                gap_event_d = 1'b1;
              end
            end else begin
              byte_cnt_d = byte_next;
            end
          end
        end

        STOPPED: begin
          if (bus.block_gap_control_register[1] && !bus.block_gap_control_register[0])
            state_d = ACTIVE;
        end

        COMPLETE: begin
          state_d     = IDLE;
          xfer_done_d = 1'b1;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      blk_size_q   <= '0;
      byte_cnt_q   <= '0;
      blocks_rem_q <= '0;
      block_done_q <= 1'b0;
      gap_event_q  <= 1'b0;
      xfer_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctrl_q       <= ctrl_d;
      blk_size_q   <= blk_size_d;
      byte_cnt_q   <= byte_cnt_d;
      blocks_rem_q <= blocks_rem_d;
      block_done_q <= block_done_d;
      gap_event_q  <= gap_event_d;
      xfer_done_q  <= xfer_done_d;
    end
  end

  assign in_xfer = (state_q == ACTIVE) || (state_q == STOPPED);

  assign bus.dma_request           = (state_q == ACTIVE) && ctrl_q.dma_en;
  assign bus.read_transfer_active  = in_xfer && ctrl_q.dir;
  assign bus.write_transfer_active = in_xfer && !ctrl_q.dir;
  assign bus.block_done            = block_done_q;
  assign bus.block_gap_event       = gap_event_q;
  assign bus.transfer_complete     = xfer_done_q;
  assign bus.blocks_remaining      = blocks_rem_q;

  // Register fields this controller does not decode.
  assign unused_bits = ^{bus.transfer_mode_register[15:6],
                         bus.transfer_mode_register[3:2],
                         bus.block_gap_control_register[7:2]};

endmodule

// File: tb/tb_dma_transfer_ctrl.sv
// Self-checking bench for dma_transfer_ctrl: directed scenarios plus randomized
// transfers compared against block/word arithmetic derived from the transfer rules.
module tb_dma_transfer_ctrl;
  localparam int BLK_CNT_W  = 16;
  localparam int BLK_SIZE_W = 12;
  localparam int DB         = 4;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  // Pulse tallies, written only by the monitor below.
  int bd_cnt  = 0;
  int gap_cnt = 0;
  int tc_cnt  = 0;
  int rem_log[$];

  dma_transfer_ctrl_if #(.BLK_CNT_W(BLK_CNT_W), .BLK_SIZE_W(BLK_SIZE_W)) bif ();

  dma_transfer_ctrl #(
    .BLK_CNT_W (BLK_CNT_W),
    .BLK_SIZE_W(BLK_SIZE_W),
    .DATA_BYTES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.block_done) begin
      bd_cnt++;
      rem_log.push_back(int'(bif.blocks_remaining));
    end
    if (bif.block_gap_event)   gap_cnt++;
    if (bif.transfer_complete) tc_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic logic [5:0] all_flags();
    return {bif.read_transfer_active, bif.write_transfer_active, bif.dma_request,
            bif.block_done, bif.block_gap_event, bif.transfer_complete};
  endfunction

  // One whole transfer. Expectations come from: words per block = ceil(size/DB),
  // loaded count = 1 (single) or the block count register (multi), and the
  // count falls by one per block unless in infinite mode.
  task automatic run_xfer(input bit multi, input bit cnt_en, input bit dir, input bit dma_en,
                          input int bcr, input int size, input int stop_blk, input int inf_blocks);
    int words, nblk, init_rem, exp_rem, bd0, gap0, tc0, log0, exp_gaps;
    bit counted, gap_here, last_blk;
    words    = (size + DB - 1) / DB;
    counted  = !multi || cnt_en;
    init_rem = multi ? bcr : 1;
    nblk     = counted ? init_rem : inf_blocks;
    exp_gaps = 0;
    bd0  = bd_cnt;
    gap0 = gap_cnt;
    tc0  = tc_cnt;
    log0 = rem_log.size();

    bif.transfer_mode_register = {10'($urandom), multi, dir, 2'($urandom), cnt_en, dma_en};
    bif.block_count_register   = 16'(bcr);
    bif.block_size             = 12'(size);
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    bif.transfer_mode_register = 16'($urandom);
    bif.block_count_register   = 16'($urandom);

    if (counted && init_rem == 0) begin
      check("zero_cnt_flags", 32'(all_flags()), 32'd0);
      tick();
      check("zero_cnt_tc", bif.transfer_complete, 1);
      tick();
      check("zero_cnt_tc_end", bif.transfer_complete, 0);
      check("zero_cnt_no_bd", bd_cnt - bd0, 0);
      return;
    end

    check("loaded_rem", bif.blocks_remaining, init_rem);
    check("dma_req_start", bif.dma_request, dma_en);
    check("rd_act_start", bif.read_transfer_active, dir);
    check("wr_act_start", bif.write_transfer_active, !dir);

    bif.start = 1'b1;
    bif.block_count_register = 16'(init_rem + 7);
    tick();
    bif.start = 1'b0;
    check("restart_ignored", bif.blocks_remaining, init_rem);

    for (int b = 0; b < nblk; b++) begin
      last_blk = (b == nblk - 1);
      gap_here = (b == stop_blk) && !(counted && last_blk);
      exp_rem  = counted ? init_rem - 1 - b : init_rem;
      if (b == stop_blk)
        bif.block_gap_control_register = 8'h01 | (8'($urandom) & 8'hfc);
      for (int w = 0; w < words; w++) begin
        repeat ($urandom_range(0, 2)) tick();
        bif.word_done = 1'b1;
        tick();
        bif.word_done = 1'b0;
        check("block_done", bif.block_done, w == words - 1);
        check("gap_event", bif.block_gap_event, (w == words - 1) && gap_here);
        if (w != words - 1) check("dma_req_mid", bif.dma_request, dma_en);
      end
      check("rem_after_block", bif.blocks_remaining, exp_rem);
      bif.block_gap_control_register = 8'h00;
      if (gap_here) begin
        exp_gaps++;
        check("stopped_no_dma", bif.dma_request, 0);
        check("stopped_rd", bif.read_transfer_active, dir);
        check("stopped_wr", bif.write_transfer_active, !dir);
        bif.word_done = 1'b1;
        repeat (3) tick();
        bif.word_done = 1'b0;
        check("stopped_rem", bif.blocks_remaining, exp_rem);
        check("stopped_no_bd", bif.block_done, 0);
        bif.block_gap_control_register = 8'h03;
        tick();
        check("stop_wins_dma", bif.dma_request, 0);
        check("stop_wins_act", bif.read_transfer_active | bif.write_transfer_active, 1);
        bif.block_gap_control_register = 8'h02;
        tick();
        bif.block_gap_control_register = 8'h00;
        check("resumed_dma", bif.dma_request, dma_en);
        check("resumed_act", bif.read_transfer_active | bif.write_transfer_active, 1);
      end
    end

    if (counted) begin
      check("complete_flags_off", bif.read_transfer_active | bif.write_transfer_active, 0);
      tick();
      check("tc_pulse", bif.transfer_complete, 1);
      tick();
      check("tc_end", bif.transfer_complete, 0);
      check("tc_count", tc_cnt - tc0, 1);
    end else begin
      bif.abort = 1'b1;
      tick();
      bif.abort = 1'b0;
      check("abort_flags", 32'(all_flags()), 32'd0);
      check("abort_rem", bif.blocks_remaining, 0);
      tick();
      check("inf_no_tc", tc_cnt - tc0, 0);
    end

    check("bd_count", bd_cnt - bd0, nblk);
    check("gap_count", gap_cnt - gap0, exp_gaps);
    check("rem_log_len", rem_log.size(), log0 + nblk);
    for (int i = 0; i < nblk && log0 + i < rem_log.size(); i++)
      check("rem_at_bd", rem_log[log0 + i], counted ? init_rem - 1 - i : init_rem);
  endtask

  initial begin
    int mode, n, sz, stop;
    bif.transfer_mode_register     = '0;
    bif.block_count_register       = '0;
    bif.block_size                 = '0;
    bif.block_gap_control_register = '0;
    bif.start     = 1'b0;
    bif.abort     = 1'b0;
    bif.word_done = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) tick();
    check("reset_flags", 32'(all_flags()), 32'd0);
    check("reset_rem", bif.blocks_remaining, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-block read, 8 bytes.
    run_xfer(1'b0, 1'b0, 1'b1, 1'b1, 0, 8, -1, 0);
    // Counted multi-block write, 3 blocks of 6 bytes, DMA disabled.
    run_xfer(1'b1, 1'b1, 1'b0, 1'b0, 3, 6, -1, 0);
    // Counted 4 blocks with a gap stop after the second block.
    run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 4, 12, 1, 0);
    // Infinite mode, 5 blocks, then abort.
    run_xfer(1'b1, 1'b0, 1'b1, 1'b1, 7, 8, -1, 5);
    // Counted with zero blocks.
    run_xfer(1'b1, 1'b1, 1'b0, 1'b1, 0, 8, -1, 0);

    // Zero block size: Start ignored.
    bif.transfer_mode_register = 16'h0033;
    bif.block_count_register   = 16'd5;
    bif.block_size             = '0;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    check("size0_flags", 32'(all_flags()), 32'd0);
    check("size0_rem", bif.blocks_remaining, 0);
    tick();
    check("size0_no_tc", bif.transfer_complete, 0);

    // Abort mid-block, with a coincident Word_Done, then a fresh transfer.
    bif.transfer_mode_register = 16'h0011;
    bif.block_size             = 12'd20;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    bif.word_done = 1'b1;
    tick();
    bif.abort = 1'b1;
    tick();
    bif.abort = 1'b0;
    bif.word_done = 1'b0;
    check("abort_mid_flags", 32'(all_flags()), 32'd0);
    check("abort_mid_rem", bif.blocks_remaining, 0);
    run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 0, 20, -1, 0);

    // Asynchronous reset in the middle of a block.
    bif.transfer_mode_register = 16'h0011;
    bif.block_size             = 12'd16;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    bif.word_done = 1'b1;
    tick();
    bif.word_done = 1'b0;
    check("pre_rst_active", bif.read_transfer_active, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_flags", 32'(all_flags()), 32'd0);
    check("rst_async_rem", bif.blocks_remaining, 0);
    @(negedge clk);
    rst = 1'b0;
    run_xfer(1'b0, 1'b0, 1'b1, 1'b0, 0, 16, -1, 0);

    // Randomized transfers.
    for (int t = 0; t < 10; t++) begin
      mode = $urandom_range(0, 2);
      n    = $urandom_range(0, 5);
      sz   = $urandom_range(1, 40);
      stop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4)) : -1;
      run_xfer(mode != 0, (mode == 1) ? 1'b1 : ((mode == 0) ? 1'($urandom) : 1'b0),
               1'($urandom), 1'($urandom), n, sz, stop, $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
